jstk_spi_responder: RTL and testbench

//  SPI slave (mode 0, MSB first) that answers the joystick SPI master with a 5-byte PmodJSTK-format frame.

---
 rtl/jstk_spi_responder_pkg.sv | 16 +
 rtl/jstk_spi_responder_spi_pin_sync.sv | 27 ++
 rtl/jstk_spi_responder.sv | 88 ++++++++
 tb/tb_jstk_spi_responder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/jstk_spi_responder_pkg.sv
// jstk_spi_responder_pkg: shared constants, FSM states and PmodJSTK frame layout
package jstk_spi_responder_pkg;
  localparam int JSTK_CMD_VALID = 7;
  localparam int JSTK_FRAME_BITS = 40;
  localparam int X_LO = 4, X_HI = 3, Y_LO = 2, Y_HI = 1, BTN = 0;
  typedef enum logic [1:0] {WAIT_IDLE = 2'd0, IDLE = 2'd1, XFER = 2'd2} state_t;
  function automatic logic [JSTK_FRAME_BITS-1:0] jstk_frame(input logic [9:0] x, input logic [9:0] y, input logic [2:0] btn);
    logic [4:0][7:0] b;
    b[X_LO] = x[7:0];
    b[X_HI] = {6'b0, x[9:8]};
    b[Y_LO] = y[7:0];
    b[Y_HI] = {6'b0, y[9:8]};
    b[BTN] = {5'b0, btn};
    return b;
  endfunction
endpackage

// File: rtl/jstk_spi_responder_spi_pin_sync.sv
// jstk_spi_responder_spi_pin_sync: N-stage synchronizer with registered rise/fall pulses
module jstk_spi_responder_spi_pin_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [N-1:0] sr;
  logic prev;
  assign q = sr[N-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sr <= {sr[N-2:0], d};
      prev <= sr[N-1];
      rise <= sr[N-1] & ~prev;
      fall <= ~sr[N-1] & prev;
    end
endmodule

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: mode-0 SPI slave returning a PmodJSTK frame, all logic in the clk50M domain
module jstk_spi_responder
  import jstk_spi_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BYTES = 5
) (
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [2:0] btn,
  output logic       ld1,
  output logic       ld2,
  output logic       frame_done,
  output logic       frame_err
);
  localparam int FB = FRAME_BYTES * 8;
  localparam int CW = $clog2(FB + 1);
  logic cs_q, cs_rise, cs_fall, sck_rise, sck_fall, mosi_q;
  logic sck_q_unused, mosi_rise_unused, mosi_fall_unused;
  state_t state;
  logic [FB-1:0] tx_sr;
  logic [7:0] rx_sr, cmd, rx_next;
  logic [CW-1:0] bit_cnt;
  logic [JSTK_FRAME_BITS-1:0] snap;
  logic full;
  assign rx_next = {rx_sr[6:0], mosi_q};
  assign snap = jstk_frame(x, y, btn);
  assign full = bit_cnt == CW'(FB);
  jstk_spi_responder_spi_pin_sync #(.N(SYNC_STAGES)) u_cs (.clk(clk50M), .rst_n(rst_n), .d(cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  jstk_spi_responder_spi_pin_sync #(.N(SYNC_STAGES)) u_sck (.clk(clk50M), .rst_n(rst_n), .d(sck), .q(sck_q_unused), .rise(sck_rise), .fall(sck_fall));
  jstk_spi_responder_spi_pin_sync #(.N(SYNC_STAGES)) u_mosi (.clk(clk50M), .rst_n(rst_n), .d(mosi), .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused));
  always_ff @(posedge clk50M or negedge rst_n)
    if (!rst_n) begin
      state <= WAIT_IDLE;
      tx_sr <= '0;
      rx_sr <= '0;
      cmd <= '0;
      bit_cnt <= '0;
      miso <= 1'b0;
      miso_oe <= 1'b0;
      ld1 <= 1'b0;
      ld2 <= 1'b0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        WAIT_IDLE: state <= cs_q ? IDLE : WAIT_IDLE;
        IDLE:
          if (cs_fall) begin
            tx_sr <= FB'(snap) << (FB - JSTK_FRAME_BITS);
            bit_cnt <= '0;
            miso <= snap[JSTK_FRAME_BITS-1];
            miso_oe <= 1'b1;
            state <= XFER;
          end
        XFER:
          // cs rise outranks any sck edge landing in the same cycle
          if (cs_rise) begin
            miso <= 1'b0;
            miso_oe <= 1'b0;
            state <= IDLE;
            frame_done <= full;
            frame_err <= ~full;
            if (full && cmd[JSTK_CMD_VALID]) begin
              ld1 <= cmd[0];
              ld2 <= cmd[1];
            end
          end else if (sck_rise) begin
            rx_sr <= rx_next;
            bit_cnt <= full ? bit_cnt : bit_cnt + CW'(1);
            if (bit_cnt == CW'(7)) cmd <= rx_next;
          end else if (sck_fall) begin
            tx_sr <= {tx_sr[FB-2:0], 1'b0};
            miso <= tx_sr[FB-2];
          end
        default: state <= WAIT_IDLE;
      endcase
    end
endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb_jstk_spi_responder: table vectors, hand sequences and random frames against a byte-level model
module tb_jstk_spi_responder;
  logic clk50M = 1'b0, rst_n = 1'b0, cs = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic [2:0] btn = '0;
  logic miso, miso_oe, ld1, ld2, frame_done, frame_err;
  int n_checks = 0, n_fail = 0, done_cnt = 0, err_cnt = 0;
  logic m_ld1 = 1'b0, m_ld2 = 1'b0;

  typedef struct {
    logic [9:0] x, y;
    logic [2:0] btn;
    logic [7:0] cmd;
    int nbits;
    logic [39:0] exp_rx;
    logic ld1, ld2;
    int done, err;
  } vec_t;
  vec_t vecs [6];

  always #10 clk50M = ~clk50M;

  jstk_spi_responder dut (
    .clk50M(clk50M), .rst_n(rst_n), .cs(cs), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .x(x), .y(y), .btn(btn),
    .ld1(ld1), .ld2(ld2), .frame_done(frame_done), .frame_err(frame_err)
  );

  always @(negedge clk50M) begin
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk50M);
  endtask

  // Frame bytes X_LO, X_HI, Y_LO, Y_HI, BTN as plain arithmetic on the reported values
  function automatic logic [39:0] model_bytes(input logic [9:0] xv, input logic [9:0] yv, input logic [2:0] bv);
    int b [5];
    logic [39:0] r;
    b[0] = xv % 256; b[1] = xv / 256; b[2] = yv % 256; b[3] = yv / 256; b[4] = bv;
    r = '0;
    for (int i = 0; i < 5; i++) r = r * 256 + 40'(b[i]);
    return r;
  endfunction

  // evkind: 0 none, 1 change x before bit evbit, 2 pulse rst_n before bit evbit
  task automatic spi_xfer(input logic [7:0] cmd, input int nbits, input int half, input int evbit,
                          input int evkind, output logic [47:0] rx, output logic oe_bad);
    logic [39:0] tx;
    tx = {cmd, 32'h0};
    rx = '0;
    oe_bad = 1'b0;
    cs = 1'b0;
    mosi = tx[39];
    clks(half);
    for (int b = 0; b < nbits; b++) begin
      if (b == evbit && evkind == 1) x = 10'h3FF;
      if (b == evbit && evkind == 2) begin
        rst_n = 1'b0;
        #1;
        check("rst_midframe_outputs", {miso, miso_oe, ld1, ld2, frame_done, frame_err}, 0);
        clks(2);
        rst_n = 1'b1;
      end
      if (evkind == 2 && b > evbit && miso_oe) oe_bad = 1'b1;
      if (b < 48) rx[47-b] = miso;
      sck = 1'b1;
      clks(half);
      sck = 1'b0;
      tx = tx << 1;
      mosi = tx[39];
      clks(half);
    end
    cs = 1'b1;
    clks(half + 8);
  endtask

  task automatic do_frame(input string name, input logic [9:0] xv, input logic [9:0] yv, input logic [2:0] bv,
                          input logic [7:0] cmd, input int nbits, input int half, input int evbit, input int evkind,
                          input logic [39:0] exp_rx, input logic e_ld1, input logic e_ld2, input int e_done, input int e_err);
    int d0, e0, k;
    logic [47:0] rx;
    logic oe_bad;
    x = xv; y = yv; btn = bv;
    clks(2);
    d0 = done_cnt; e0 = err_cnt;
    spi_xfer(cmd, nbits, half, evbit, evkind, rx, oe_bad);
    k = (evkind == 2) ? evbit : (nbits < 40 ? nbits : 40);
    check({name, "_rx"}, rx[47:8] >> (40 - k), exp_rx >> (40 - k));
    if (nbits > 40 && evkind != 2) check({name, "_overflow_miso"}, rx[7:0], 0);
    if (evkind == 2) check({name, "_oe_after_reset"}, oe_bad, 0);
    check({name, "_ld"}, {ld1, ld2}, {e_ld1, e_ld2});
    check({name, "_done"}, done_cnt - d0, e_done);
    check({name, "_err"}, err_cnt - e0, e_err);
  endtask

  task automatic run_model(input string name, input logic [9:0] xv, input logic [9:0] yv, input logic [2:0] bv,
                           input logic [7:0] cmd, input int nbits, input int half, input int evbit, input int evkind);
    logic full;
    full = (evkind != 2) && (nbits >= 40);
    if (evkind == 2) begin
      m_ld1 = 1'b0; m_ld2 = 1'b0;
    end else if (full && cmd[7]) begin
      m_ld1 = cmd[0]; m_ld2 = cmd[1];
    end
    do_frame(name, xv, yv, bv, cmd, nbits, half, evbit, evkind, model_bytes(xv, yv, bv),
             m_ld1, m_ld2, int'(full), int'(evkind != 2 && nbits < 40));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic oe_seen;
    vecs[0] = '{10'h2A5, 10'h13C, 3'b101, 8'h83, 40, 40'hA5023C0105, 1'b1, 1'b1, 1, 0};
    vecs[1] = '{10'h000, 10'h3FF, 3'b010, 8'h03, 40, 40'h0000FF0302, 1'b1, 1'b1, 1, 0};
    vecs[2] = '{10'h1FF, 10'h000, 3'b111, 8'h80, 40, 40'hFF01000007, 1'b0, 1'b0, 1, 0};
    vecs[3] = '{10'h155, 10'h2AA, 3'b000, 8'h81, 20, 40'h5501AA0200, 1'b0, 1'b0, 0, 1};
    vecs[4] = '{10'h155, 10'h2AA, 3'b000, 8'h82, 40, 40'h5501AA0200, 1'b0, 1'b1, 1, 0};
    vecs[5] = '{10'h3FF, 10'h001, 3'b001, 8'h81, 48, 40'hFF03010001, 1'b1, 1'b0, 1, 0};

    // Reset with random pin activity, then release while cs is low
    for (int i = 0; i < 6; i++) begin
      cs = 1'($urandom); sck = 1'($urandom); mosi = 1'($urandom); x = 10'($urandom);
      clks(1);
      check("reset_outputs", {miso, miso_oe, ld1, ld2, frame_done, frame_err}, 0);
    end
    cs = 1'b0; sck = 1'b0;
    clks(2);
    rst_n = 1'b1;
    oe_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom);
      sck = 1'b1; clks(5);
      oe_seen |= miso_oe;
      sck = 1'b0; clks(5);
      oe_seen |= miso_oe;
    end
    check("no_response_before_idle", oe_seen, 0);
    cs = 1'b1;
    clks(12);
    check("no_pulses_after_reset", done_cnt + err_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      do_frame($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].btn, vecs[i].cmd, vecs[i].nbits, 25, -1, 0,
               vecs[i].exp_rx, vecs[i].ld1, vecs[i].ld2, vecs[i].done, vecs[i].err);
      m_ld1 = vecs[i].ld1; m_ld2 = vecs[i].ld2;
    end

    run_model("x_change_midframe", 10'h0A5, 10'h155, 3'b011, 8'h00, 40, 10, 3, 1);
    run_model("after_x_change", 10'h3FF, 10'h155, 3'b011, 8'h00, 40, 10, -1, 0);
    run_model("reset_midframe", 10'h123, 10'h321, 3'b110, 8'h83, 40, 10, 25, 2);
    run_model("after_reset", 10'h2C4, 10'h04B, 3'b100, 8'h83, 40, 10, -1, 0);

    for (int i = 0; i < 10; i++) begin
      int r, nb;
      r = $urandom_range(0, 3);
      nb = (r < 2) ? 40 : (r == 2 ? int'($urandom_range(1, 39)) : 44);
      run_model($sformatf("rand%0d", i), 10'($urandom), 10'($urandom), 3'($urandom), 8'($urandom),
                nb, $urandom_range(5, 8), -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
